event_uart_tx: RTL and testbench

Output-side transmitter for the event path. It accepts filtered events (2-bit x, 2-bit y, 2-bit polarity, 2-bit timestamp, packed as one byte) and buffers them in a small FIFO. Each buffered event is sent off-chip as one asynchronous serial frame on a single pin. In the top level it sits downstream of the event filter, with its serial line and status driven onto the bidirectional pins.

---
 rtl/event_pkg.sv | 33 +++
 rtl/event_fifo.sv | 71 +++++++
 rtl/event_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_event_uart_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// ---------------------------------------------------------------------------
// event_pkg
// Shared definitions for the event path: event field widths, serial frame
// constants and the transmitter FSM state type.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package event_pkg;

   // Event byte layout {x, y, p, t}, x in the top bits
   localparam int X_W  = 2;
   localparam int Y_W  = 2;
   localparam int P_W  = 2;
   localparam int T_W  = 2;
   localparam int EV_W = X_W + Y_W + P_W + T_W;

   // Serial frame: start + data + parity + stop
   localparam int   DATA_BITS  = 8;
   localparam int   FRAME_BITS = 11;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/event_fifo.sv
// ---------------------------------------------------------------------------
// event_fifo
// Synchronous event FIFO, DEPTH entries of EV_W bits, head visible on dout.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, din        write request and data (ignored while full)
//   pop, dout        read request (ignored while empty) and current head
//   full, empty      occupancy flags
//   level            occupancy 0..DEPTH
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module event_fifo
   import event_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [EV_W-1:0] din,
   input  logic            pop,
   output logic [EV_W-1:0] dout,
   output logic            full,
   output logic            empty,
   output logic [LW-1:0]   level
);

   logic [EV_W-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   // Acceptance is judged on the pre-edge count, so a push while full is
   // rejected even if a pop happens on the same edge.
   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; stale entries are never visible past the pointers
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/event_uart_tx.sv
// ---------------------------------------------------------------------------
// event_uart_tx
// Buffers filtered events and sends each as an 11-bit serial frame
// (start, 8 data bits LSB first, even parity, stop).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ev_data      event byte {x, y, p, t}
//   ev_valid     ev_data valid this cycle
//   ev_ready     FIFO not full
//   tx           registered serial line, idles high
//   busy         frame on the line or events queued
//   overflow     sticky: an event arrived while the FIFO was full
//   level        FIFO occupancy
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module event_uart_tx
   import event_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4,
   localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [EV_W-1:0] ev_data,
   input  logic            ev_valid,
   output logic            ev_ready,
   output logic            tx,
   output logic            busy,
   output logic            overflow,
   output logic [LW-1:0]   level
);

   localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

   tx_state_t       state;
   logic [7:0]      bit_cnt;
   logic [2:0]      bit_idx;
   logic [EV_W-1:0] shreg;
   logic            parity;
   logic            tx_q;
   logic            ovf_q;

   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;
   logic [EV_W-1:0] head;
   logic            bit_end;

   event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ev_valid),
      .din   (ev_data),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign bit_end  = (bit_cnt == BIT_LAST);
   // A new head is taken from IDLE at once, or at the end of a stop bit so
   // back-to-back frames have no idle gap.
   assign fifo_pop = ~fifo_empty &
                     ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

   assign ev_ready = ~fifo_full;
   assign tx       = tx_q;
   assign overflow = ovf_q;
   assign busy     = (state != ST_IDLE) | (level != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (ev_valid && fifo_full) begin
         ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         parity  <= 1'b0;
         tx_q    <= IDLE_LEVEL;
      end else begin
         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               if (fifo_pop) begin
                  state  <= ST_START;
                  shreg  <= head;
                  parity <= 1'b0;
                  tx_q   <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  tx_q    <= shreg[0];
                  parity  <= shreg[0];
                  shreg   <= shreg >> 1;
               end else begin
                  bit_cnt <= bit_cnt + 8'd1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
                     // parity has accumulated every data bit driven so far
                     state <= ST_PARITY;
                     tx_q  <= parity;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= shreg[0];
                     parity  <= parity ^ shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 8'd1;
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  state   <= ST_STOP;
                  bit_cnt <= '0;
                  tx_q    <= IDLE_LEVEL;
               end else begin
                  bit_cnt <= bit_cnt + 8'd1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (fifo_pop) begin
                     state  <= ST_START;
                     shreg  <= head;
                     parity <= 1'b0;
                     tx_q   <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                     tx_q  <= IDLE_LEVEL;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 8'd1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               bit_cnt <= '0;
               tx_q    <= IDLE_LEVEL;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_event_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_event_uart_tx
// Self-checking bench for event_uart_tx: directed scenarios plus random
// event traffic, compared every cycle against a queue/frame-timeline model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_event_uart_tx;

   localparam int CPB       = 4;
   localparam int DEPTH     = 4;
   localparam int LW        = $clog2(DEPTH) + 1;
   localparam int FRAME_CYC = 11 * CPB;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic [7:0]    ev_data  = 8'h00;
   logic          ev_valid = 1'b0;
   logic          ev_ready;
   logic          tx;
   logic          busy;
   logic          overflow;
   logic [LW-1:0] level;

   int n_total = 0;
   int n_bad   = 0;

   event_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ev_data  (ev_data),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .tx       (tx),
      .busy     (busy),
      .overflow (overflow),
      .level    (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Queue of accepted events plus a frame timeline: a frame is the 11-bit
   // sequence built from the byte, and bit n is on the line for CPB cycles.
   logic [7:0]  m_q[$];
   bit          m_active = 1'b0;
   int          m_t      = 0;
   logic [10:0] m_bits   = 11'h7FF;
   bit          m_ovf    = 1'b0;

   function automatic logic [10:0] frame_of(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
      f[9]  = ^b;
      f[10] = 1'b1;
      return f;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_active = 1'b0;
         m_t      = 0;
         m_ovf    = 1'b0;
      end else begin
         int  sz0;
         bit  acc;
         sz0 = m_q.size();
         acc = ev_valid && (sz0 < DEPTH);
         if (ev_valid && !acc) m_ovf = 1'b1;
         if (m_active) begin
            m_t++;
            if (m_t == FRAME_CYC) m_active = 1'b0;
         end
         if (!m_active && sz0 > 0) begin
            m_bits   = frame_of(m_q.pop_front());
            m_active = 1'b1;
            m_t      = 0;
         end
         if (acc) m_q.push_back(ev_data);
      end
   end

   function automatic logic exp_tx();
      return m_active ? m_bits[m_t / CPB] : 1'b1;
   endfunction

   always @(negedge clk) begin
      chk("tx",       32'(tx),       32'(exp_tx()));
      chk("busy",     32'(busy),     32'(m_active || (m_q.size() > 0)));
      chk("level",    32'(level),    32'(m_q.size()));
      chk("ev_ready", 32'(ev_ready), 32'(m_q.size() < DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] d);
      ev_data  = d;
      ev_valid = 1'b1;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [10:0] a5_frame;
      a5_frame = 11'b1_0_1010_0101_0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx",       32'(tx),       32'd1);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_level",    32'(level),    32'd0);
      chk("rst_ready",    32'(ev_ready), 32'd1);
      rst_n = 1'b1;
      idle(2);

      // single 0xA5 frame: bit-by-bit, then busy falls 45 edges after accept
      send(8'hA5);
      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) begin
         chk("a5_bit", 32'(tx), 32'(a5_frame[i]));
         repeat (CPB) @(posedge clk);
         #1;
      end
      chk("a5_busy_end", 32'(busy), 32'd0);
      chk("a5_tx_end",   32'(tx),   32'd1);
      idle(5);

      // odd-weight byte -> parity bit 1
      send(8'h07);
      idle(FRAME_CYC + 6);

      // four-event burst: back-to-back frames, no overflow
      for (int i = 1; i <= 4; i++) send(8'(i));
      idle(4 * FRAME_CYC + 8);
      chk("burst4_ovf", 32'(overflow), 32'd0);

      // six-event burst: fifth fills the FIFO, sixth is dropped
      for (int i = 0; i < 5; i++) send(8'h11 + 8'(i));
      chk("burst6_ready", 32'(ev_ready), 32'd0);
      send(8'h16);
      chk("burst6_ovf", 32'(overflow), 32'd1);
      idle(5 * FRAME_CYC + 8);

      // asynchronous reset in the middle of a DATA bit, with one event queued
      send(8'h3C);
      send(8'h5A);
      idle(10);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx",    32'(tx),       32'd1);
      chk("mid_rst_busy",  32'(busy),     32'd0);
      chk("mid_rst_level", 32'(level),    32'd0);
      chk("mid_rst_ovf",   32'(overflow), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2 * FRAME_CYC);

      // push exactly on the STOP->START edge with one event queued
      send(8'hC3);
      send(8'h96);
      idle(FRAME_CYC - 1);
      send(8'h69);
      chk("stop_push_level", 32'(level), 32'd1);
      chk("stop_push_tx",    32'(tx),    32'd0);
      idle(2 * FRAME_CYC + 8);

      // random traffic at several densities
      foreach (m_q[i]) begin end
      for (int ph = 0; ph < 3; ph++) begin
         int dens;
         dens = (ph == 0) ? 5 : (ph == 1) ? 20 : 60;
         for (int c = 0; c < 300; c++) begin
            ev_data  = 8'($urandom);
            ev_valid = ($urandom_range(0, 99) < dens);
            @(posedge clk);
            #1;
         end
         ev_valid = 1'b0;
      end
      idle((DEPTH + 1) * FRAME_CYC + 8);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
